// File: rtl/even_parity_frame_rx_pkg.sv
// Shared definitions for the even-parity serial frame receiver:
// FSM state encodings and the idle level of the serial line.
package even_parity_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/even_parity_frame_rx_if.sv
// Output side of the frame receiver: one-entry buffer with valid/ready handshake.
interface even_parity_frame_rx_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] out_data;
  logic              out_parity_err;
  logic              out_frame_err;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_parity_err,
    output out_frame_err,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_parity_err,
    input  out_frame_err,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/even_parity_frame_rx_calc.sv
// Parameterised-width parity (XOR reduction) of a data word; shared with the generator side.
module even_parity_calc #(
  parameter int W = 4
) (
  input  logic [W-1:0] data,
  output logic         parity
);
  logic [W-1:0] chain;

  assign chain[0] = data[0];

  generate
    for (genvar gi = 1; gi < W; gi++) begin : g_xor
      assign chain[gi] = chain[gi-1] ^ data[gi];
    end
  endgenerate

  assign parity = chain[W-1];
endmodule

// File: rtl/even_parity_frame_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, even parity, stop.
// Delivers words through a one-entry buffer and tracks overrun and error counts.
module even_parity_frame_rx
  import even_parity_frame_rx_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bit_en,
  input  logic                     rxd,
  even_parity_frame_rx_if.master   out,
  output logic                     overrun,
  output logic [ERR_CNT_W-1:0]     err_cnt,
  input  logic                     err_clr
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_t             state_reg;
  logic [DATA_W-1:0]     shift_reg;
  logic [DATA_W-1:0]     shift_next;
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic                  par_bit_reg;
  logic [DATA_W-1:0]     data_reg;
  logic                  perr_reg;
  logic                  ferr_reg;
  logic                  valid_reg;
  logic                  overrun_reg;
  logic [ERR_CNT_W-1:0]  err_cnt_reg;

  logic data_parity;
  logic frame_done;
  logic parity_err;
  logic frame_err;
  logic load;
  logic drop;
  logic accept;

  // Right shift: after DATA_W samples the first received bit sits in bit 0.
  generate
    if (DATA_W == 1) begin : g_shift_one
      assign shift_next = rxd;
    end else begin : g_shift_wide
      assign shift_next = {rxd, shift_reg[DATA_W-1:1]};
    end
  endgenerate

  even_parity_calc #(.W(DATA_W)) u_parity (
    .data   (shift_reg),
    .parity (data_parity)
  );

  assign frame_done = bit_en && (state_reg == STOP);
  assign parity_err = data_parity ^ par_bit_reg;
  assign frame_err  = ~rxd;
  assign accept     = valid_reg && out.out_ready;
  assign load       = frame_done && (!valid_reg || out.out_ready);
  assign drop       = frame_done && valid_reg && !out.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      par_bit_reg <= 1'b0;
      data_reg    <= '0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      if (bit_en) begin
        case (state_reg)
          IDLE: begin
            if (rxd != IDLE_LEVEL) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
              shift_reg   <= '0;
            end
          end
          DATA: begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg <= PARITY;
            end
          end
          PARITY: begin
            par_bit_reg <= rxd;
            state_reg   <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end

      // A completion in the same cycle as an accept refills the buffer.
      if (load) begin
        data_reg  <= shift_reg;
        perr_reg  <= parity_err;
        ferr_reg  <= frame_err;
        valid_reg <= 1'b1;
      end else if (accept) begin
        valid_reg <= 1'b0;
      end

      if (err_clr) begin
        overrun_reg <= 1'b0;
      end else if (drop) begin
        overrun_reg <= 1'b1;
      end

      if (err_clr) begin
        err_cnt_reg <= '0;
      end else if (frame_done && (parity_err || frame_err) && !(&err_cnt_reg)) begin
        err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
      end
    end
  end

  assign out.out_data       = data_reg;
  assign out.out_parity_err = perr_reg;
  assign out.out_frame_err  = ferr_reg;
  assign out.out_valid      = valid_reg;
  assign overrun            = overrun_reg;
  assign err_cnt            = err_cnt_reg;

endmodule

// File: tb/tb_even_parity_frame_rx.sv
// Directed bench for even_parity_frame_rx (DATA_W=4, ERR_CNT_W=2).
module tb_even_parity_frame_rx;

  logic       clk;
  logic       rst_n;
  logic       bit_en;
  logic       rxd;
  logic       overrun;
  logic [1:0] err_cnt;
  logic       err_clr;

  int n_vec;
  int n_err;

  even_parity_frame_rx_if #(.DATA_W(4)) rx_if ();

  even_parity_frame_rx #(.DATA_W(4), .ERR_CNT_W(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_en  (bit_en),
    .rxd     (rxd),
    .out     (rx_if),
    .overrun (overrun),
    .err_cnt (err_cnt),
    .err_clr (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives one strobed bit across the next rising edge.
  task automatic strobe(input logic b);
    rxd    = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    rxd    = 1'b1;
  endtask

  task automatic send_body(input logic [3:0] d, input logic p);
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(d[i]);
    strobe(p);
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic s);
    send_body(d, p);
    strobe(s);
    $display("frame d=%h p=%0d s=%0d -> valid=%0d data=%h perr=%0d ferr=%0d ovr=%0d cnt=%0d",
             d, p, s, rx_if.out_valid, rx_if.out_data, rx_if.out_parity_err,
             rx_if.out_frame_err, overrun, err_cnt);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bit_en = 1'b0;
    rxd = 1'b1;
    err_clr = 1'b0;
    rx_if.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(rx_if.out_valid), 32'h0);
    chk("rst_data", 32'(rx_if.out_data), 32'h0);
    chk("rst_perr", 32'(rx_if.out_parity_err), 32'h0);
    chk("rst_ferr", 32'(rx_if.out_frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_errcnt", 32'(err_cnt), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle line with continuous strobes
    for (int i = 0; i < 20; i++) strobe(1'b1);
    chk("idle_valid", 32'(rx_if.out_valid), 32'h0);
    chk("idle_errcnt", 32'(err_cnt), 32'h0);
    chk("idle_overrun", 32'(overrun), 32'h0);

    // Clean frame 4'hD, p=1
    rx_if.out_ready = 1'b1;
    send_frame(4'hD, 1'b1, 1'b1);
    chk("clean_valid", 32'(rx_if.out_valid), 32'h1);
    chk("clean_data", 32'(rx_if.out_data), 32'hD);
    chk("clean_perr", 32'(rx_if.out_parity_err), 32'h0);
    chk("clean_ferr", 32'(rx_if.out_frame_err), 32'h0);
    chk("clean_errcnt", 32'(err_cnt), 32'h0);
    @(negedge clk);
    chk("clean_pulse_end", 32'(rx_if.out_valid), 32'h0);

    // Parity error: 4'h3 with p=1
    send_frame(4'h3, 1'b1, 1'b1);
    chk("perr_data", 32'(rx_if.out_data), 32'h3);
    chk("perr_flag", 32'(rx_if.out_parity_err), 32'h1);
    chk("perr_ferr", 32'(rx_if.out_frame_err), 32'h0);
    chk("perr_errcnt", 32'(err_cnt), 32'h1);
    @(negedge clk);

    // Frame error: 4'hF, p=0, stop=0
    send_frame(4'hF, 1'b0, 1'b0);
    chk("ferr_data", 32'(rx_if.out_data), 32'hF);
    chk("ferr_flag", 32'(rx_if.out_frame_err), 32'h1);
    chk("ferr_perr", 32'(rx_if.out_parity_err), 32'h0);
    chk("ferr_errcnt", 32'(err_cnt), 32'h2);
    @(negedge clk);
    chk("ferr_consumed", 32'(rx_if.out_valid), 32'h0);

    // Backpressure: 4'hA held, 4'h5 dropped
    rx_if.out_ready = 1'b0;
    send_frame(4'hA, 1'b0, 1'b1);
    chk("bp_first_valid", 32'(rx_if.out_valid), 32'h1);
    send_frame(4'h5, 1'b0, 1'b1);
    chk("bp_hold_data", 32'(rx_if.out_data), 32'hA);
    chk("bp_hold_valid", 32'(rx_if.out_valid), 32'h1);
    chk("bp_overrun", 32'(overrun), 32'h1);
    chk("bp_errcnt", 32'(err_cnt), 32'h2);
    rx_if.out_ready = 1'b1;
    @(negedge clk);
    rx_if.out_ready = 1'b0;
    chk("bp_accept", 32'(rx_if.out_valid), 32'h0);
    chk("bp_overrun_sticky", 32'(overrun), 32'h1);

    // Clear sticky state, then accept and completion in the same cycle
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_overrun", 32'(overrun), 32'h0);
    chk("clr_errcnt", 32'(err_cnt), 32'h0);
    send_frame(4'h3, 1'b0, 1'b1);
    chk("sim_first_data", 32'(rx_if.out_data), 32'h3);
    send_body(4'h6, 1'b0);
    rx_if.out_ready = 1'b1;
    strobe(1'b1);
    rx_if.out_ready = 1'b0;
    $display("frame d=6 with accept -> valid=%0d data=%h ovr=%0d",
             rx_if.out_valid, rx_if.out_data, overrun);
    chk("sim_valid", 32'(rx_if.out_valid), 32'h1);
    chk("sim_data", 32'(rx_if.out_data), 32'h6);
    chk("sim_overrun", 32'(overrun), 32'h0);
    rx_if.out_ready = 1'b1;
    @(negedge clk);
    chk("sim_drain", 32'(rx_if.out_valid), 32'h0);

    // Saturation: five parity-error frames on a 2-bit counter
    for (int k = 1; k <= 5; k++) begin
      rx_if.out_ready = (k < 5);
      send_frame(4'h3, 1'b1, 1'b1);
      chk("sat_errcnt", 32'(err_cnt), (k < 3) ? 32'(k) : 32'd3);
      @(negedge clk);
    end
    chk("sat_full_valid", 32'(rx_if.out_valid), 32'h1);
    // Sixth error frame overruns while err_clr is pulsed
    send_body(4'h3, 1'b1);
    err_clr = 1'b1;
    strobe(1'b1);
    err_clr = 1'b0;
    $display("frame d=3 with err_clr -> cnt=%0d ovr=%0d", err_cnt, overrun);
    chk("satclr_errcnt", 32'(err_cnt), 32'h0);
    chk("satclr_overrun", 32'(overrun), 32'h0);
    chk("satclr_valid", 32'(rx_if.out_valid), 32'h1);
    rx_if.out_ready = 1'b1;
    @(negedge clk);
    rx_if.out_ready = 1'b0;

    // Async reset in the middle of a frame, with a pending word and errors
    send_frame(4'h3, 1'b1, 1'b1);
    chk("pre_rst_valid", 32'(rx_if.out_valid), 32'h1);
    chk("pre_rst_errcnt", 32'(err_cnt), 32'h1);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rx_if.out_valid), 32'h0);
    chk("arst_data", 32'(rx_if.out_data), 32'h0);
    chk("arst_perr", 32'(rx_if.out_parity_err), 32'h0);
    chk("arst_errcnt", 32'(err_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) strobe(1'b1);
    chk("no_phantom", 32'(rx_if.out_valid), 32'h0);
    rx_if.out_ready = 1'b1;
    send_frame(4'h9, 1'b0, 1'b1);
    chk("post_rst_valid", 32'(rx_if.out_valid), 32'h1);
    chk("post_rst_data", 32'(rx_if.out_data), 32'h9);
    chk("post_rst_perr", 32'(rx_if.out_parity_err), 32'h0);
    chk("post_rst_ferr", 32'(rx_if.out_frame_err), 32'h0);
    chk("post_rst_errcnt", 32'(err_cnt), 32'h0);
    @(negedge clk);
    chk("post_rst_drain", 32'(rx_if.out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/even_parity_frame_rx.md
Name: even_parity_frame_rx

Overview:
- Downstream consumer of the 4-bit even parity generator's output. Receives a serial frame: start bit, DATA_W data bits LSB first (b0 first), even-parity bit, stop bit.
- Checks parity and framing, holds the recovered word in a one-entry output buffer with a valid/ready handshake, and counts errors.
- Sits between the serial link and the parallel data consumer.

Parameters:
- DATA_W, 4, number of data bits per frame (>=1).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset. Asserts immediately; deassertion is synchronous to clk (externally synchronised).
- bit_en  input  1  one-cycle strobe marking the sample point of each serial bit.
- rxd  input  1  serial line, idle high; sampled only when bit_en=1.
- out_data  output  DATA_W  received data word; out_data[0] is the first bit received.
- out_parity_err  output  1  parity mismatch flag, qualified by out_valid.
- out_frame_err  output  1  stop bit was 0, qualified by out_valid.
- out_valid  output  1  buffer holds an undelivered frame.
- out_ready  input  1  consumer accepts the frame when out_valid && out_ready.
- overrun  output  1  sticky: a completed frame was dropped because the buffer was full.
- err_cnt  output  ERR_CNT_W  saturating count of frames with a parity or frame error.
- err_clr  input  1  synchronous clear of err_cnt and overrun.

Behaviour:
- Reset values: out_data=0, out_parity_err=0, out_frame_err=0, out_valid=0, overrun=0, err_cnt=0. FSM enters IDLE; shift register and bit counter are cleared.
- Reset mid-frame aborts the frame. The frame is not delivered and no counter changes.
- FSM states: IDLE, DATA, PARITY, STOP. The FSM advances only on cycles with bit_en=1.
  - IDLE: bit_en && rxd=0 -> DATA, bit_cnt=0. rxd=1 stays in IDLE. A held-low line therefore retriggers a frame on every idle sample; this is accepted.
  - DATA: on each bit_en, shift rxd into bit position bit_cnt and increment. After the DATA_W-th sample -> PARITY.
  - PARITY: on bit_en, capture p=rxd -> STOP.
  - STOP: on bit_en, complete the frame and return to IDLE.
- Checks, evaluated at frame completion:
  - parity_err = XOR of all data bits XOR p. Even parity means the total count of ones, including p, is even.
  - frame_err = (stop sample == 0). The frame is still delivered with the flag set.
- Latency: out_valid rises on the clock edge after the cycle that carries the stop-bit sample (bit_en in STOP).
- Handshake:
  - out_valid stays high until the cycle in which out_ready=1. It clears on the following edge.
  - out_data and the error flags remain stable while out_valid=1.
- Completion while the buffer is occupied:
  - If out_valid=1 and out_ready=1 in that same cycle, the new frame replaces the old one and out_valid stays 1. No overrun.
  - If out_valid=1 and out_ready=0, the new frame is dropped, the old frame is kept, and overrun is set.
- err_cnt:
  - Increments by 1 on each completed frame with parity_err|frame_err, including dropped frames.
  - Saturates at all-ones and does not wrap.
  - If err_clr and an increment fall in the same cycle, the clear wins and err_cnt=0.
- overrun is cleared only by err_clr or reset. If err_clr coincides with a new overrun, the clear wins.
- bit_en asserted on consecutive cycles is legal; each strobe is one bit.

Decomposition:
- Shared package/include file: FSM state encodings (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3) and the idle-line level constant (1'b1).
- One sub-module, even_parity_calc: parameterised-width XOR reduction producing the parity of the shifted data. It is reusable by the matching generator.

Test Plan:
- Reset idle: rxd=1 with continuous bit_en for 20 strobes -> out_valid=0, err_cnt=0, overrun=0.
- Clean frame: serial 0,1,0,1,1,1,1 (start, data 4'b1101 LSB first, p=1, stop=1), out_ready=1 -> one out_valid pulse with out_data=4'hD, out_parity_err=0, out_frame_err=0, err_cnt=0.
- Parity error: data 4'b0011 with p=1, stop=1 -> out_data=4'h3, out_parity_err=1, err_cnt=1. Then data 4'hF, p=0, stop=0 -> out_frame_err=1, out_parity_err=0, err_cnt=2.
- Backpressure: out_ready=0, send 4'hA then 4'h5 -> out_data stays 4'hA and overrun=1. Assert out_ready -> 4'hA is accepted and out_valid drops. Simultaneous accept and completion of 4'h6 -> out_valid stays 1 with out_data=4'h6 and overrun unchanged.
- Saturation and clear: ERR_CNT_W=2, send 5 parity-error frames -> err_cnt=3. Pulse err_clr in the same cycle as a 6th error completion -> err_cnt=0 and overrun=0.
- Async reset mid-frame: assert rst_n=0 after 2 data bits -> outputs clear immediately. Release and send 4'h9 with p=0 -> out_data=4'h9, with no error and no phantom frame.
